// File: rtl/lcv_mul_acc_arb.sv
// lcv_mul_acc_arb: round-robin arbitrated signed multiply-accumulate with per-requester accumulators
module lcv_mul_acc_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][15:0]       req_a,
  input  logic [NUM_REQ-1:0][15:0]       req_b,
  input  logic [NUM_REQ-1:0][32:0]       req_c,
  input  logic [NUM_REQ-1:0]             req_acc,
  input  logic [NUM_REQ-1:0]             req_clr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [32:0]                    rsp_data,
  output logic [ID_WIDTH-1:0]            rsp_id
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] last_q, sel, cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0][32:0] acc_q;
  logic slot_free, accept;
  logic signed [31:0] prod;
  logic [32:0] addend, result;
  // Scan from farthest to nearest so the nearest valid requester after last_q wins.
  always_comb begin
    grant = '0;
    sel = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant = '0;
        grant[cand] = 1'b1;
        sel = cand;
      end
    end
  end
  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = (rst && slot_free) ? grant : '0;
  assign accept = |req_ready;
  assign prod = $signed(req_a[sel]) * $signed(req_b[sel]);
  assign addend = req_clr[sel] ? 33'd0 : req_acc[sel] ? acc_q[sel] : req_c[sel];
  assign result = {prod[31], prod} + addend;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      acc_q <= '0;
      last_q <= PW'(NUM_REQ - 1);
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data <= result;
      rsp_id <= ID_WIDTH'(sel);
      acc_q[sel] <= result;
      last_q <= sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
